// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c_master and the arbiter in front of it.
// Holds the arbiter state encoding and the width helpers for master ports.
package i2c_pkg;

    // One-hot encoding keeps the next-state decode shallow.
    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_LOAD  = 5'b00010,
        ST_START = 5'b00100,
        ST_WAIT  = 5'b01000,
        ST_DONE  = 5'b10000
    } arb_state_e;

    localparam int I2C_ADDR_W = 7;

    function automatic int transfer_length_size(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int interface_size(input int max_len);
        return max_len * 8;
    endfunction

endpackage

// File: rtl/i2c_master_arbiter_rr_priority_select.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Ports: req, ptr in; valid, onehot winner, idx of winner out.
module rr_priority_select #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        // Walk from the farthest offset down so the nearest one wins.
        for (int off = N - 1; off >= 0; off--) begin
            int cand;
            cand = (int'(ptr) + off) % N;
            if (req[cand]) begin
                valid = 1'b1;
                idx   = IW'(cand);
            end
        end
        if (valid) begin
            onehot = {{(N-1){1'b0}}, 1'b1} << idx;
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master among NUM_REQ clients.
// Ports: per-client req/descriptor in, done/grant/rsp_* out, m_* to master.
module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ             = 2,
    parameter int MAX_TRANSFER_LENGTH = 1,
    localparam int TRANSFER_LENGTH_SIZE =
        transfer_length_size(MAX_TRANSFER_LENGTH),
    localparam int INTERFACE_SIZE =
        interface_size(MAX_TRANSFER_LENGTH)
) (
    input  logic clk,
    input  logic rst,

    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ*7-1:0] req_i2c_address,
    input  logic [NUM_REQ*INTERFACE_SIZE-1:0] req_write_data,
    input  logic [NUM_REQ*TRANSFER_LENGTH_SIZE-1:0] req_write_length,
    input  logic [NUM_REQ*TRANSFER_LENGTH_SIZE-1:0] req_read_length,

    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic [INTERFACE_SIZE-1:0] rsp_read_data,
    output logic rsp_no_response,
    output logic rsp_len_err,
    output logic [TRANSFER_LENGTH_SIZE-1:0] rsp_total_written,
    output logic [TRANSFER_LENGTH_SIZE-1:0] rsp_total_read,

    output logic [6:0] m_i2c_address,
    output logic [INTERFACE_SIZE-1:0] m_write_data,
    output logic [TRANSFER_LENGTH_SIZE-1:0] m_write_transfer_length,
    output logic [TRANSFER_LENGTH_SIZE-1:0] m_read_transfer_length,
    output logic m_start,
    input  logic m_busy,
    input  logic m_no_response,
    input  logic [INTERFACE_SIZE-1:0] m_read_data,
    input  logic [TRANSFER_LENGTH_SIZE-1:0] m_total_written,
    input  logic [TRANSFER_LENGTH_SIZE-1:0] m_total_read
);

    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TLS = TRANSFER_LENGTH_SIZE;
    localparam int IS  = INTERFACE_SIZE;

    arb_state_e state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] win_idx_q, win_idx_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;

    logic [6:0] m_addr_q, m_addr_d;
    logic [IS-1:0] m_wdata_q, m_wdata_d;
    logic [TLS-1:0] m_wlen_q, m_wlen_d;
    logic [TLS-1:0] m_rlen_q, m_rlen_d;
    logic m_start_q, m_start_d;

    logic [IS-1:0] rsp_rdata_q, rsp_rdata_d;
    logic rsp_nr_q, rsp_nr_d;
    logic rsp_lerr_q, rsp_lerr_d;
    logic [TLS-1:0] rsp_tw_q, rsp_tw_d;
    logic [TLS-1:0] rsp_tr_q, rsp_tr_d;

    logic sel_valid;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [IW-1:0] sel_idx;

    logic [6:0] win_addr;
    logic [IS-1:0] win_wdata;
    logic [TLS-1:0] win_wlen;
    logic [TLS-1:0] win_rlen;

    rr_priority_select #(
        .N (NUM_REQ)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .valid  (sel_valid),
        .onehot (sel_onehot),
        .idx    (sel_idx)
    );

    // Descriptor of the client latched as winner in IDLE.
    always_comb begin
        win_addr  = req_i2c_address[int'(win_idx_q)*7 +: 7];
        win_wdata = req_write_data[int'(win_idx_q)*IS +: IS];
        win_wlen  = req_write_length[int'(win_idx_q)*TLS +: TLS];
        win_rlen  = req_read_length[int'(win_idx_q)*TLS +: TLS];
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_idx_d   = win_idx_q;
        grant_d     = grant_q;
        done_d      = '0;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_wlen_d    = m_wlen_q;
        m_rlen_d    = m_rlen_q;
        m_start_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_nr_d    = rsp_nr_q;
        rsp_lerr_d  = rsp_lerr_q;
        rsp_tw_d    = rsp_tw_q;
        rsp_tr_d    = rsp_tr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!m_start_q && !m_busy && sel_valid) begin
                    grant_d   = sel_onehot;
                    win_idx_d = sel_idx;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                m_addr_d  = win_addr;
                m_wdata_d = win_wdata;
                m_wlen_d  = win_wlen;
                m_rlen_d  = win_rlen;
                // A zero-length start would hang the master busy.
                if (win_wlen == '0 && win_rlen == '0) begin
                    state_d     = ST_DONE;
                    done_d      = grant_q;
                    rsp_lerr_d  = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_nr_d    = 1'b0;
                    rsp_tw_d    = '0;
                    rsp_tr_d    = '0;
                end else begin
                    state_d   = ST_START;
                    m_start_d = 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!m_busy) begin
                    state_d     = ST_DONE;
                    done_d      = grant_q;
                    rsp_lerr_d  = 1'b0;
                    rsp_rdata_d = m_read_data;
                    rsp_nr_d    = m_no_response;
                    rsp_tw_d    = m_total_written;
                    rsp_tr_d    = m_total_read;
                end
            end
            ST_DONE: begin
                grant_d = '0;
                state_d = ST_IDLE;
                if (win_idx_q == IW'(NUM_REQ - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = win_idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            win_idx_q   <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_wlen_q    <= '0;
            m_rlen_q    <= '0;
            m_start_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_nr_q    <= 1'b0;
            rsp_lerr_q  <= 1'b0;
            rsp_tw_q    <= '0;
            rsp_tr_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_idx_q   <= win_idx_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_wlen_q    <= m_wlen_d;
            m_rlen_q    <= m_rlen_d;
            m_start_q   <= m_start_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_nr_q    <= rsp_nr_d;
            rsp_lerr_q  <= rsp_lerr_d;
            rsp_tw_q    <= rsp_tw_d;
            rsp_tr_q    <= rsp_tr_d;
        end
    end

    assign done                    = done_q;
    assign grant                   = grant_q;
    assign rsp_read_data           = rsp_rdata_q;
    assign rsp_no_response         = rsp_nr_q;
    assign rsp_len_err             = rsp_lerr_q;
    assign rsp_total_written       = rsp_tw_q;
    assign rsp_total_read          = rsp_tr_q;
    assign m_i2c_address           = m_addr_q;
    assign m_write_data            = m_wdata_q;
    assign m_write_transfer_length = m_wlen_q;
    assign m_read_transfer_length  = m_rlen_q;
    assign m_start                 = m_start_q;

endmodule
